fft_radix2_iter: RTL and testbench

- Parametrised iterative radix-2 decimation-in-time FFT/IFFT engine; the next generation of the fixed 8-point wide-bus FFT.
- Samples stream in one per handshake and are stored bit-reversed in an internal register array.
- Transform runs in place, one butterfly per cycle; results stream out in natural order with backpressure.
- Sits between the sample capture path and the spectral post-processing path.

---
 rtl/fft_radix2_iter.sv | 257 +++++++++++++++++++++++++
 tb/tb_fft_radix2_iter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_radix2_iter.sv
// Iterative radix-2 decimation-in-time FFT/IFFT engine.
// Samples are loaded one per handshake into a bit-reversed register array,
// transformed in place with one butterfly per cycle, then streamed out in
// natural order under downstream backpressure.
module fft_radix2_iter #(
  parameter int N_POINTS = 8,
  parameter int DATA_W   = 16,
  parameter int TW_W     = 16,
  parameter int SCALE    = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic signed [DATA_W-1:0] i_data_re,
  input  logic signed [DATA_W-1:0] i_data_im,
  input  logic                     i_inverse,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic signed [DATA_W-1:0] o_data_re,
  output logic signed [DATA_W-1:0] o_data_im,
  output logic                     o_last,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int  STAGES = $clog2(N_POINTS);
  localparam int  ADDR_W = STAGES;
  localparam int  BFLY_W = STAGES - 1;
  localparam int  HALF   = N_POINTS / 2;
  localparam int  PW     = DATA_W + TW_W + 1;
  localparam int  SW     = DATA_W + 1;
  localparam real PI     = 3.14159265358979323846;
  localparam real TW_ONE = (1 << (TW_W - 2)) * 1.0;

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_COMPUTE = 2'd1,
    S_UNLOAD  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] r_ocnt;
  logic [BFLY_W-1:0] r_bfly;
  logic [ADDR_W-1:0] r_stage;
  logic              r_inv;
  logic              r_done;

  logic signed [DATA_W-1:0] r_mem_re [N_POINTS];
  logic signed [DATA_W-1:0] r_mem_im [N_POINTS];

  logic signed [TW_W-1:0] w_tw_cos [HALF];
  logic signed [TW_W-1:0] w_tw_sin [HALF];

  logic              w_in_hs;
  logic              w_out_hs;
  logic              w_load_last;
  logic              w_cmp_last;
  logic              w_out_last;

  logic [ADDR_W-1:0] w_j;
  logic [ADDR_W-1:0] w_hbit;
  logic [ADDR_W-1:0] w_hmask;
  logic [ADDR_W-1:0] w_top;
  logic [ADDR_W-1:0] w_bot;
  logic [BFLY_W-1:0] w_tw_k;

  logic signed [TW_W-1:0]   w_w_re;
  logic signed [TW_W-1:0]   w_w_im;
  logic signed [DATA_W-1:0] w_a_re;
  logic signed [DATA_W-1:0] w_a_im;
  logic signed [DATA_W-1:0] w_b_re;
  logic signed [DATA_W-1:0] w_b_im;
  logic signed [PW-1:0]     w_tr_full;
  logic signed [PW-1:0]     w_ti_full;
  logic signed [SW-1:0]     w_t_re;
  logic signed [SW-1:0]     w_t_im;
  logic signed [SW-1:0]     w_sum_re;
  logic signed [SW-1:0]     w_sum_im;
  logic signed [SW-1:0]     w_dif_re;
  logic signed [SW-1:0]     w_dif_im;
  logic signed [DATA_W-1:0] w_new_a_re;
  logic signed [DATA_W-1:0] w_new_a_im;
  logic signed [DATA_W-1:0] w_new_b_re;
  logic signed [DATA_W-1:0] w_new_b_im;

  // Reverse the bit order of an array address.
  function automatic logic [ADDR_W-1:0] f_bitrev(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    for (int i = 0; i < ADDR_W; i++) begin
      r[i] = a[ADDR_W-1-i];
    end
    return r;
  endfunction

  // Round a full-precision twiddle product back to data scale (half-up).
  function automatic logic signed [SW-1:0] f_round_tw(input logic signed [PW-1:0] x);
    return SW'((x + PW'(1 << (TW_W - 3))) >>> (TW_W - 2));
  endfunction

  // Per-stage growth control: halve (floor) or saturate to DATA_W.
  function automatic logic signed [DATA_W-1:0] f_scale_sat(input logic signed [SW-1:0] x);
    logic signed [DATA_W-1:0] y;
    if (SCALE != 0) begin
      y = DATA_W'(x >>> 1);
    end else if (x[SW-1] != x[SW-2]) begin
      y = x[SW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      y = DATA_W'(x);
    end
    return y;
  endfunction

  // Twiddle ROM: W^k = cos(2*pi*k/N) - j*sin(2*pi*k/N), rounded to nearest.
  // The sine table holds +sin; the sign is applied per mode below.
  for (genvar g = 0; g < HALF; g++) begin : g_tw
    localparam real ANG   = 2.0 * PI * g / N_POINTS;
    localparam int  COS_I = $rtoi($floor($cos(ANG) * TW_ONE + 0.5));
    localparam int  SIN_I = $rtoi($floor($sin(ANG) * TW_ONE + 0.5));
    assign w_tw_cos[g] = TW_W'(COS_I);
    assign w_tw_sin[g] = TW_W'(SIN_I);
  end

  assign w_in_hs     = (r_state == S_LOAD) && i_valid;
  assign w_out_hs    = (r_state == S_UNLOAD) && i_ready;
  assign w_load_last = w_in_hs && (r_cnt == ADDR_W'(N_POINTS - 1));
  assign w_cmp_last  = (r_state == S_COMPUTE) && (r_bfly == BFLY_W'(HALF - 1)) &&
                       (r_stage == ADDR_W'(STAGES - 1));
  assign w_out_last  = w_out_hs && (r_ocnt == ADDR_W'(N_POINTS - 1));

  // Butterfly addressing for span h = 2^stage:
  // top = (j/h)*2h + (j mod h), bot = top + h, k = (j mod h) * N/(2h).
  assign w_j     = {1'b0, r_bfly};
  assign w_hbit  = ADDR_W'(1) << r_stage;
  assign w_hmask = w_hbit - ADDR_W'(1);
  assign w_top   = ((w_j >> r_stage) << (r_stage + ADDR_W'(1))) | (w_j & w_hmask);
  assign w_bot   = w_top | w_hbit;
  assign w_tw_k  = BFLY_W'((w_j & w_hmask) << (ADDR_W'(STAGES - 1) - r_stage));

  // Inverse transform uses the conjugate twiddle.
  assign w_w_re = w_tw_cos[w_tw_k];
  assign w_w_im = r_inv ? w_tw_sin[w_tw_k] : -w_tw_sin[w_tw_k];

  assign w_a_re = r_mem_re[w_top];
  assign w_a_im = r_mem_im[w_top];
  assign w_b_re = r_mem_re[w_bot];
  assign w_b_im = r_mem_im[w_bot];

  // t = B * W at full precision, then rounded to DATA_W+1 bits.
  assign w_tr_full = PW'(w_b_re) * PW'(w_w_re) - PW'(w_b_im) * PW'(w_w_im);
  assign w_ti_full = PW'(w_b_re) * PW'(w_w_im) + PW'(w_b_im) * PW'(w_w_re);
  assign w_t_re    = f_round_tw(w_tr_full);
  assign w_t_im    = f_round_tw(w_ti_full);

  assign w_sum_re = SW'(w_a_re) + w_t_re;
  assign w_sum_im = SW'(w_a_im) + w_t_im;
  assign w_dif_re = SW'(w_a_re) - w_t_re;
  assign w_dif_im = SW'(w_a_im) - w_t_im;

  assign w_new_a_re = f_scale_sat(w_sum_re);
  assign w_new_a_im = f_scale_sat(w_sum_im);
  assign w_new_b_re = f_scale_sat(w_dif_re);
  assign w_new_b_im = f_scale_sat(w_dif_im);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and output decode.
  always_comb begin
    w_state_nxt = r_state;
    o_ready     = 1'b0;
    o_valid     = 1'b0;
    o_busy      = 1'b0;
    o_last      = 1'b0;
    o_data_re   = '0;
    o_data_im   = '0;
    case (r_state)
      S_LOAD: begin
        o_ready = 1'b1;
        if (w_load_last) w_state_nxt = S_COMPUTE;
      end
      S_COMPUTE: begin
        o_busy = 1'b1;
        if (w_cmp_last) w_state_nxt = S_UNLOAD;
      end
      S_UNLOAD: begin
        o_valid   = 1'b1;
        o_busy    = 1'b1;
        o_last    = (r_ocnt == ADDR_W'(N_POINTS - 1));
        o_data_re = r_mem_re[r_ocnt];
        o_data_im = r_mem_im[r_ocnt];
        if (w_out_last) w_state_nxt = S_LOAD;
      end
      default: w_state_nxt = S_LOAD;
    endcase
  end

  // Load counter and transform direction, latched on the first sample.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_inv <= 1'b0;
    end else if (w_in_hs) begin
      r_cnt <= r_cnt + ADDR_W'(1);
      if (r_cnt == '0) r_inv <= i_inverse;
    end
  end

  // Butterfly and stage counters; both return to zero after the last stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bfly  <= '0;
      r_stage <= '0;
    end else if (r_state == S_COMPUTE) begin
      r_bfly <= r_bfly + BFLY_W'(1);
      if (r_bfly == BFLY_W'(HALF - 1)) begin
        r_stage <= (r_stage == ADDR_W'(STAGES - 1)) ? '0 : r_stage + ADDR_W'(1);
      end
    end
  end

  // Output bin counter and end-of-frame pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ocnt <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_out_last;
      if (w_out_hs) r_ocnt <= r_ocnt + ADDR_W'(1);
    end
  end

  assign o_done = r_done;

  // Sample array: bit-reversed writes while loading, in-place butterflies while computing.
  always_ff @(posedge i_clk) begin
    if (w_in_hs) begin
      r_mem_re[f_bitrev(r_cnt)] <= i_data_re;
      r_mem_im[f_bitrev(r_cnt)] <= i_data_im;
    end else if (r_state == S_COMPUTE) begin
      r_mem_re[w_top] <= w_new_a_re;
      r_mem_im[w_top] <= w_new_a_im;
      r_mem_re[w_bot] <= w_new_b_re;
      r_mem_im[w_bot] <= w_new_b_im;
    end
  end

endmodule

// File: tb/tb_fft_radix2_iter.sv
// Directed bench for fft_radix2_iter (N=8, 16-bit): one scaling instance and
// one saturating instance share all inputs.
module tb_fft_radix2_iter;
  localparam int N  = 8;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic                 i_valid;
  logic                 i_ready;
  logic                 i_inverse;
  logic signed [DW-1:0] i_data_re;
  logic signed [DW-1:0] i_data_im;

  logic                 o_ready, o_valid, o_last, o_busy, o_done;
  logic signed [DW-1:0] o_data_re, o_data_im;
  logic                 s0_o_ready, s0_o_valid, s0_o_last, s0_o_busy, s0_o_done;
  logic signed [DW-1:0] s0_o_data_re, s0_o_data_im;

  fft_radix2_iter #(.N_POINTS(N), .DATA_W(DW), .TW_W(16), .SCALE(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_data_re(i_data_re), .i_data_im(i_data_im), .i_inverse(i_inverse),
    .o_valid(o_valid), .i_ready(i_ready), .o_data_re(o_data_re), .o_data_im(o_data_im),
    .o_last(o_last), .o_busy(o_busy), .o_done(o_done)
  );

  fft_radix2_iter #(.N_POINTS(N), .DATA_W(DW), .TW_W(16), .SCALE(0)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(s0_o_ready),
    .i_data_re(i_data_re), .i_data_im(i_data_im), .i_inverse(i_inverse),
    .o_valid(s0_o_valid), .i_ready(i_ready), .o_data_re(s0_o_data_re), .o_data_im(s0_o_data_im),
    .o_last(s0_o_last), .o_busy(s0_o_busy), .o_done(s0_o_done)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic signed [DW-1:0] stim_re [N];
  logic signed [DW-1:0] stim_im [N];
  logic signed [DW-1:0] got_re [N];
  logic signed [DW-1:0] got_im [N];
  logic signed [DW-1:0] got_s0_re [N];
  logic signed [DW-1:0] got_s0_im [N];
  logic signed [DW-1:0] ref_re [N];
  logic signed [DW-1:0] ref_im [N];
  logic [N-1:0]         got_last;
  logic                 got_done;
  logic                 got_idle_after;
  int                   got_count;
  int                   got_ready_low;
  int                   got_unstable;
  int                   got_stalls;
  int                   got_loaded;

  task automatic set_stim(input int v0, input int v1, input int rest);
    for (int k = 0; k < N; k++) begin
      stim_re[k] = DW'(rest);
      stim_im[k] = '0;
    end
    stim_re[0] = DW'(v0);
    stim_re[1] = DW'(v1);
  endtask

  // Present the stimulus, advancing only when the block is ready.
  task automatic send_frame(input logic inv);
    int i;
    int guard;
    i = 0;
    guard = 0;
    while (i < N && guard < 100) begin
      @(negedge clk);
      i_valid   = 1'b1;
      i_data_re = stim_re[i];
      i_data_im = stim_im[i];
      i_inverse = inv;
      if (o_ready) i++;
      guard++;
    end
    @(negedge clk);
    i_valid   = 1'b0;
    i_data_re = '0;
    i_data_im = '0;
    i_inverse = 1'b0;
    got_loaded = i;
  endtask

  // Gather one output frame; optionally stall downstream pseudo-randomly.
  task automatic collect_frame(input bit stall);
    int idx;
    int guard;
    logic held_v;
    logic signed [DW-1:0] held_re;
    logic signed [DW-1:0] held_im;
    idx = 0; guard = 0; held_v = 1'b0; held_re = '0; held_im = '0;
    got_last = '0; got_ready_low = 0; got_unstable = 0; got_stalls = 0;
    while (idx < N && guard < 400) begin
      if (!o_ready) got_ready_low++;
      i_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (o_valid) begin
        if (held_v && (o_data_re !== held_re || o_data_im !== held_im)) got_unstable++;
        if (i_ready) begin
          got_re[idx]    = o_data_re;
          got_im[idx]    = o_data_im;
          got_s0_re[idx] = s0_o_data_re;
          got_s0_im[idx] = s0_o_data_im;
          got_last[idx]  = o_last;
          idx++;
          held_v = 1'b0;
        end else begin
          got_stalls++;
          held_v  = 1'b1;
          held_re = o_data_re;
          held_im = o_data_im;
        end
      end
      guard++;
      @(negedge clk);
    end
    got_count      = idx;
    got_done       = o_done;
    got_idle_after = !o_valid && o_ready;
    i_ready        = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_inverse = 1'b0;
    i_data_re = '0; i_data_im = '0;
    repeat (3) @(negedge clk);
    n_total++; if (o_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", o_valid); else n_pass++;
    n_total++; if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", o_busy); else n_pass++;
    n_total++; if (o_done !== 1'b0 || o_last !== 1'b0) $display("FAIL reset_done_last: got %b%b expected 00", o_done, o_last); else n_pass++;
    n_total++; if (o_data_re !== 16'sd0 || o_data_im !== 16'sd0) $display("FAIL reset_data: got (%0d,%0d) expected (0,0)", o_data_re, o_data_im); else n_pass++;
    n_total++; if (s0_o_valid !== 1'b0 || s0_o_busy !== 1'b0) $display("FAIL reset_sat_ctrl: got %b%b expected 00", s0_o_valid, s0_o_busy); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_total++; if (o_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", o_ready); else n_pass++;
  endtask

  task automatic test_impulse;
    set_stim(1024, 0, 0);
    send_frame(1'b0);
    collect_frame(1'b0);
    n_total++; if (got_count != N) $display("FAIL impulse_count: got %0d bins expected %0d", got_count, N); else n_pass++;
    for (int k = 0; k < N; k++) begin
      n_total++;
      if (got_re[k] !== 16'sd128 || got_im[k] !== 16'sd0)
        $display("FAIL impulse_bin%0d: got (%0d,%0d) expected (128,0)", k, got_re[k], got_im[k]);
      else n_pass++;
    end
    n_total++; if (got_last !== 8'h80) $display("FAIL impulse_last: got %b expected 10000000", got_last); else n_pass++;
    n_total++; if (got_done !== 1'b1) $display("FAIL impulse_done: got %b expected 1", got_done); else n_pass++;
    n_total++; if (got_idle_after !== 1'b1) $display("FAIL impulse_back_to_load: got %b expected 1", got_idle_after); else n_pass++;
  endtask

  task automatic test_dc;
    set_stim(800, 800, 800);
    send_frame(1'b0);
    collect_frame(1'b0);
    n_total++; if (got_loaded != N) $display("FAIL dc_loaded: got %0d expected %0d", got_loaded, N); else n_pass++;
    n_total++; if (got_re[0] !== 16'sd800 || got_im[0] !== 16'sd0) $display("FAIL dc_bin0: got (%0d,%0d) expected (800,0)", got_re[0], got_im[0]); else n_pass++;
    for (int k = 1; k < N; k++) begin
      n_total++;
      if (got_re[k] !== 16'sd0 || got_im[k] !== 16'sd0)
        $display("FAIL dc_bin%0d: got (%0d,%0d) expected (0,0)", k, got_re[k], got_im[k]);
      else n_pass++;
    end
    n_total++; if (got_ready_low != 20) $display("FAIL dc_ready_low_cycles: got %0d expected 20", got_ready_low); else n_pass++;
  endtask

  task automatic test_shifted;
    set_stim(0, 1024, 0);
    send_frame(1'b0);
    collect_frame(1'b0);
    n_total++; if (got_re[0] !== 16'sd128 || got_im[0] !== 16'sd0) $display("FAIL fwd_bin0: got (%0d,%0d) expected (128,0)", got_re[0], got_im[0]); else n_pass++;
    n_total++; if (got_re[2] !== 16'sd0 || got_im[2] !== -16'sd128) $display("FAIL fwd_bin2: got (%0d,%0d) expected (0,-128)", got_re[2], got_im[2]); else n_pass++;
    n_total++; if (got_re[4] !== -16'sd128 || got_im[4] !== 16'sd0) $display("FAIL fwd_bin4: got (%0d,%0d) expected (-128,0)", got_re[4], got_im[4]); else n_pass++;
    n_total++; if (got_re[6] !== 16'sd0 || got_im[6] !== 16'sd128) $display("FAIL fwd_bin6: got (%0d,%0d) expected (0,128)", got_re[6], got_im[6]); else n_pass++;
    n_total++;
    if (got_re[1] < 90 || got_re[1] > 92 || got_im[1] < -92 || got_im[1] > -90)
      $display("FAIL fwd_bin1: got (%0d,%0d) expected (91,-91) +-1", got_re[1], got_im[1]);
    else n_pass++;

    send_frame(1'b1);
    collect_frame(1'b0);
    n_total++; if (got_re[0] !== 16'sd128 || got_im[0] !== 16'sd0) $display("FAIL inv_bin0: got (%0d,%0d) expected (128,0)", got_re[0], got_im[0]); else n_pass++;
    n_total++; if (got_re[2] !== 16'sd0 || got_im[2] !== 16'sd128) $display("FAIL inv_bin2: got (%0d,%0d) expected (0,128)", got_re[2], got_im[2]); else n_pass++;
    n_total++; if (got_re[6] !== 16'sd0 || got_im[6] !== -16'sd128) $display("FAIL inv_bin6: got (%0d,%0d) expected (0,-128)", got_re[6], got_im[6]); else n_pass++;
    n_total++;
    if (got_re[1] < 90 || got_re[1] > 92 || got_im[1] < 90 || got_im[1] > 92)
      $display("FAIL inv_bin1: got (%0d,%0d) expected (91,91) +-1", got_re[1], got_im[1]);
    else n_pass++;
  endtask

  task automatic test_backpressure;
    set_stim(300, -500, 0);
    stim_im[3] = 16'sd200;
    send_frame(1'b0);
    collect_frame(1'b0);
    for (int k = 0; k < N; k++) begin
      ref_re[k] = got_re[k];
      ref_im[k] = got_im[k];
    end
    send_frame(1'b0);
    collect_frame(1'b1);
    n_total++; if (got_count != N) $display("FAIL bp_count: got %0d bins expected %0d", got_count, N); else n_pass++;
    for (int k = 0; k < N; k++) begin
      n_total++;
      if (got_re[k] !== ref_re[k] || got_im[k] !== ref_im[k])
        $display("FAIL bp_bin%0d: got (%0d,%0d) expected (%0d,%0d)", k, got_re[k], got_im[k], ref_re[k], ref_im[k]);
      else n_pass++;
    end
    n_total++; if (got_unstable != 0) $display("FAIL bp_stable: got %0d changes while stalled expected 0", got_unstable); else n_pass++;
    n_total++; if (got_last !== 8'h80) $display("FAIL bp_last: got %b expected 10000000", got_last); else n_pass++;
    n_total++; if (got_done !== 1'b1) $display("FAIL bp_done: got %b expected 1", got_done); else n_pass++;
  endtask

  task automatic test_saturate;
    set_stim(30000, 30000, 30000);
    send_frame(1'b0);
    collect_frame(1'b0);
    n_total++; if (got_s0_re[0] !== 16'sd32767 || got_s0_im[0] !== 16'sd0) $display("FAIL sat_bin0: got (%0d,%0d) expected (32767,0)", got_s0_re[0], got_s0_im[0]); else n_pass++;
    for (int k = 1; k < N; k++) begin
      n_total++;
      if (got_s0_re[k] !== 16'sd0 || got_s0_im[k] !== 16'sd0)
        $display("FAIL sat_bin%0d: got (%0d,%0d) expected (0,0)", k, got_s0_re[k], got_s0_im[k]);
      else n_pass++;
    end
    n_total++; if (got_re[0] !== 16'sd30000) $display("FAIL scaled_30000_bin0: got %0d expected 30000", got_re[0]); else n_pass++;
  endtask

  task automatic test_mid_reset;
    int seen_valid;
    set_stim(800, 800, 800);
    send_frame(1'b0);
    repeat (4) @(negedge clk);
    n_total++; if (o_busy !== 1'b1) $display("FAIL midrst_busy_before: got %b expected 1", o_busy); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (o_busy !== 1'b0 || o_valid !== 1'b0) $display("FAIL midrst_ctrl: got busy=%b valid=%b expected 0,0", o_busy, o_valid); else n_pass++;
    n_total++; if (o_data_re !== 16'sd0 || o_data_im !== 16'sd0 || o_done !== 1'b0) $display("FAIL midrst_data: got (%0d,%0d) done=%b expected (0,0) 0", o_data_re, o_data_im, o_done); else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_total++; if (o_ready !== 1'b1) $display("FAIL midrst_ready: got %b expected 1", o_ready); else n_pass++;
    seen_valid = 0;
    for (int c = 0; c < 25; c++) begin
      if (o_valid) seen_valid++;
      @(negedge clk);
    end
    n_total++; if (seen_valid != 0) $display("FAIL midrst_no_output: got %0d valid cycles expected 0", seen_valid); else n_pass++;
    set_stim(1024, 0, 0);
    send_frame(1'b0);
    collect_frame(1'b0);
    n_total++; if (got_count != N) $display("FAIL midrst_count: got %0d expected %0d", got_count, N); else n_pass++;
    for (int k = 0; k < N; k++) begin
      n_total++;
      if (got_re[k] !== 16'sd128 || got_im[k] !== 16'sd0)
        $display("FAIL midrst_bin%0d: got (%0d,%0d) expected (128,0)", k, got_re[k], got_im[k]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_dc();
    test_shifted();
    test_backpressure();
    test_saturate();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
